multi_mode_ff_reg: RTL and testbench
====================================

# multi_mode_ff_reg

WIDTH-channel, runtime-mode-selectable flip-flop register that replaces individual SR flip-flop instances in the counter datapaths. Each cycle it applies SR, JK, D or T next-state logic to every channel, or treats the whole word as a modulo-(CNT_MAX+1) up counter (BCD by default). It also provides per-channel synchronous preset and clear. The illegal SR input combination holds state and sets a sticky per-channel error flag, so it never produces X.

## Interface
- WIDTH, 4, number of flip-flop channels; must be ≥ 1
- CNT_MAX, 9, terminal value in CNT mode; must be < 2^WIDTH
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  function enable; gates mode logic only, not preset or clear
- mode  in  3  0=SR, 1=JK, 2=D, 3=T, 4=CNT, 5–7 reserved
- a  in  WIDTH  S / J / D / T input, per channel; ignored in CNT mode
- b  in  WIDTH  R / K input, per channel; ignored in D, T and CNT modes
- preset  in  WIDTH  per-channel synchronous set, active-high
- clear  in  WIDTH  per-channel synchronous clear, active-high; overrides preset
- err_clr  in  1  clears all err bits
- q  out  WIDTH  register state
- qbar  out  WIDTH  ~q, combinational
- err  out  WIDTH  sticky per-channel illegal-SR flag
- tc  out  1  terminal count: (mode==CNT) && (q==CNT_MAX), combinational

## Operation
- Priority per channel i, at each rising edge:
  - rst: q=0, err=0.
  - clear[i]: q[i]=0.
  - preset[i]: q[i]=1.
  - !en: hold.
  - Otherwise the mode function applies.
- SR: s,r = 00 hold, 01 → 0, 10 → 1, 11 → hold and err[i]=1.
- JK: 00 hold, 01 → 0, 10 → 1, 11 → toggle.
- D: q[i]=a[i].
- T: q[i]=q[i]^a[i].
- CNT:
  - If any preset or clear bit is active, next q=(q|preset)&~clear and no increment occurs that cycle.
  - Otherwise, when en is high: q==CNT_MAX → 0; q>CNT_MAX (reachable only via preset) → 0 on the next count; else q+1.
  - Increment arithmetic is WIDTH bits with no carry-out.
- Reserved modes: q holds; err unchanged; preset, clear and rst still act.
- err:
  - Sets only in SR mode, with en=1, s=r=1, and no clear or preset on that channel.
  - Cleared by err_clr or rst.
  - If err_clr and a new set occur in the same cycle, the set wins.
- A mode change takes effect on the next edge; q is never reinitialised by a mode change.

## Timing
- Reset values: q=0, qbar=all ones, err=0, tc=0 (tc is 1 after reset only if mode==CNT and CNT_MAX==0).
- Latency:
  - 1 cycle from inputs to q and err.
  - qbar and tc are combinational from q and mode, with zero additional latency.
- rst asserted mid-count overrides en, preset and clear in that cycle; counting resumes from 0 on the first edge with rst low.
- No handshake; inputs are sampled every rising edge.

## Structure
- Package multi_mode_ff_pkg:
  - Mode encodings MODE_SR, MODE_JK, MODE_D, MODE_T, MODE_CNT.
  - Mode width constant MODE_W=3.
- Sub-module ff_cell, instantiated WIDTH times in a generate loop:
  - Combinational per-bit next-state and error-set computation for SR/JK/D/T, including clear and preset override.
- The top level holds:
  - the q and err registers
  - the CNT-mode increment/wrap path, which selects between the ff_cell outputs and the counter next value
  - the tc logic

## Test plan
- Reset: rst=1 for 2 cycles with arbitrary inputs → q=0000, qbar=1111, err=0000; after release with en=0, q stays 0000.
- SR and illegal input: mode=SR, en=1, a=0011, b=0101, starting from q=0000 → q=0010 (bit0: 11 hold=0; bit1: 10 set; bit2: 01 reset; bit3: 00 hold), err=0001. Then err_clr=1 with a=b=0001 in the same cycle → err stays 0001. Then err_clr=1 with a=b=0 → err=0000.
- JK and T: mode=JK, a=b=1111 from q=1010 → 0101. Then mode=T, a=0011 → 0110.
- BCD count: mode=CNT, en=1, from q=0 for 12 cycles → 1,2,…,9,0,1,2; tc=1 exactly while q==9.
- Out-of-range and override: in CNT mode, preset=1111 for one cycle → q=15. Next count → 0. Then clear=0001 and preset=0010 in the same cycle from q=5 → q=0110 with no increment.
- Mid-count reset: count to q=7, assert rst for one cycle with en=1 → q=0. The next cycle gives q=1.

Source files
------------

// File: rtl/multi_mode_ff_pkg.sv
// Shared mode encodings for the multi-mode flip-flop register.
package multi_mode_ff_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SR  = 3'd0,
    MODE_JK  = 3'd1,
    MODE_D   = 3'd2,
    MODE_T   = 3'd3,
    MODE_CNT = 3'd4
  } mode_e;

endpackage

// File: rtl/ff_cell.sv
// One channel of the multi-mode register: next-state and illegal-SR detect.
// CNT and reserved modes hold here; the top level owns the counter path.
module ff_cell
  import multi_mode_ff_pkg::*;
(
  input  logic              q,
  input  logic              a,
  input  logic              b,
  input  logic              preset,
  input  logic              clear,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  output logic              q_next,
  output logic              err_set
);

  // Per-bit next state: clear beats preset, both beat enable and mode logic.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    q_next  = q;
    err_set = 1'b0;
    if (clear) begin
      q_next = 1'b0;
    end else if (preset) begin
      q_next = 1'b1;
    end else if (en) begin
      case (mode)
        MODE_SR: begin
          case ({a, b})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   err_set = 1'b1;  // illegal: hold and flag
            default: q_next = q;
          endcase
        end
        MODE_JK: begin
          case ({a, b})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   q_next = ~q;
            default: q_next = q;
          endcase
        end
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        default: q_next = q;  // CNT handled at the top, reserved modes hold
      endcase
    end
  end

endmodule

// File: rtl/multi_mode_ff_reg.sv
// WIDTH-channel register with runtime-selectable SR/JK/D/T behaviour per bit,
// or a whole-word modulo-(CNT_MAX+1) up counter, plus per-channel preset/clear
// and a sticky illegal-SR error flag per channel.
module multi_mode_ff_reg
  import multi_mode_ff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CNT_MAX = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  preset,
  input  logic [WIDTH-1:0]  clear,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic [WIDTH-1:0]  err,
  output logic              tc
);

  localparam logic [WIDTH-1:0] CNT_TOP = CNT_MAX[WIDTH-1:0];

  logic [WIDTH-1:0] cell_next;
  logic [WIDTH-1:0] err_set;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] q_next;
  logic             cnt_mode;
  logic             cnt_step;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .q       (q[i]),
      .a       (a[i]),
      .b       (b[i]),
      .preset  (preset[i]),
      .clear   (clear[i]),
      .en      (en),
      .mode    (mode),
      .q_next  (cell_next[i]),
      .err_set (err_set[i])
    );
  end

  assign cnt_mode = (mode == MODE_CNT);
  // Any preset/clear bit suppresses the increment; the cells then apply
  // (q|preset)&~clear since they hold in CNT mode.
  assign cnt_step = cnt_mode && en && !(|(preset | clear));

  // Counter next value: wrap at CNT_MAX, and out-of-range values (only
  // reachable via preset) also return to zero on the next count.
  always_comb begin
    cnt_next = q + WIDTH'(1);
    if (q >= CNT_TOP) cnt_next = '0;
  end

  // Select between the counter path and the per-bit cell path.
  always_comb begin
    q_next = cnt_step ? cnt_next : cell_next;
  end

  // State and sticky error registers; a new error set wins over err_clr.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      err <= '0;
    end else begin
      q   <= q_next;
      err <= (err & ~{WIDTH{err_clr}}) | err_set;
    end
  end

  assign qbar = ~q;
  assign tc   = cnt_mode && (q == CNT_TOP);

endmodule

// File: tb/tb_multi_mode_ff_reg.sv
// Directed self-checking bench for multi_mode_ff_reg (WIDTH=4, BCD counter).
module tb_multi_mode_ff_reg;
  import multi_mode_ff_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0] a, b, preset, clear;
  logic             err_clr;
  logic [WIDTH-1:0] q, qbar, err;
  logic             tc;

  int checks = 0;
  int errors = 0;

  multi_mode_ff_reg #(.WIDTH(WIDTH), .CNT_MAX(9)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .preset  (preset),
    .clear   (clear),
    .err_clr (err_clr),
    .q       (q),
    .qbar    (qbar),
    .err     (err),
    .tc      (tc)
  );

  always #5 clk = ~clk;

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = MODE_D; a = 4'b1010; b = 4'b0110;
    preset = 4'b0101; clear = 4'b0000; err_clr = 1'b0;
    tick(); tick();
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got=%b exp=0000", q); end
    checks++; if (qbar !== 4'b1111) begin errors++; $display("FAIL reset_qbar got=%b exp=1111", qbar); end
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL reset_err got=%b exp=0000", err); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
    rst = 1'b0; en = 1'b0; preset = 4'b0000; a = 4'b1111; b = 4'b0000;
    tick();
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL hold_after_reset got=%b exp=0000", q); end
  endtask

  task automatic test_sr();
    mode = MODE_SR; en = 1'b1; a = 4'b0011; b = 4'b0101;
    tick();
    checks++; if (q !== 4'b0010) begin errors++; $display("FAIL sr_q got=%b exp=0010", q); end
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL sr_err got=%b exp=0001", err); end
    err_clr = 1'b1; a = 4'b0001; b = 4'b0001;
    tick();
    checks++; if (err !== 4'b0001) begin errors++; $display("FAIL sr_set_wins got=%b exp=0001", err); end
    checks++; if (q !== 4'b0010) begin errors++; $display("FAIL sr_illegal_hold got=%b exp=0010", q); end
    a = 4'b0000; b = 4'b0000;
    tick();
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL sr_err_clr got=%b exp=0000", err); end
    err_clr = 1'b0;
  endtask

  task automatic test_jk_t();
    mode = MODE_D; a = 4'b1010; b = 4'b0000;
    tick();
    checks++; if (q !== 4'b1010) begin errors++; $display("FAIL d_load got=%b exp=1010", q); end
    mode = MODE_JK; a = 4'b1111; b = 4'b1111;
    tick();
    checks++; if (q !== 4'b0101) begin errors++; $display("FAIL jk_toggle got=%b exp=0101", q); end
    mode = MODE_T; a = 4'b0011; b = 4'b0000;
    tick();
    checks++; if (q !== 4'b0110) begin errors++; $display("FAIL t_toggle got=%b exp=0110", q); end
    checks++; if (qbar !== 4'b1001) begin errors++; $display("FAIL t_qbar got=%b exp=1001", qbar); end
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL jk_no_err got=%b exp=0000", err); end
  endtask

  task automatic test_count();
    logic [WIDTH-1:0] exp_q;
    clear = 4'b1111; a = 4'b0000;
    tick();
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL clear_all got=%b exp=0000", q); end
    clear = 4'b0000; mode = MODE_CNT; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      exp_q = 4'(i % 10);
      tick();
      checks++; if (q !== exp_q) begin errors++; $display("FAIL bcd_q step=%0d got=%0d exp=%0d", i, q, exp_q); end
      checks++; if (tc !== (exp_q == 4'd9)) begin errors++; $display("FAIL bcd_tc step=%0d got=%b exp=%b", i, tc, (exp_q == 4'd9)); end
    end
    en = 1'b0;
    tick();
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL cnt_en_hold got=%0d exp=2", q); end
    en = 1'b1;
  endtask

  task automatic test_override();
    preset = 4'b1111;
    tick();
    checks++; if (q !== 4'd15) begin errors++; $display("FAIL preset_15 got=%0d exp=15", q); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL tc_at_15 got=%b exp=0", tc); end
    preset = 4'b0000;
    tick();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL out_of_range_wrap got=%0d exp=0", q); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (q !== 4'd5) begin errors++; $display("FAIL count_to_5 got=%0d exp=5", q); end
    clear = 4'b0001; preset = 4'b0010;
    tick();
    checks++; if (q !== 4'b0110) begin errors++; $display("FAIL cnt_override got=%b exp=0110", q); end
    clear = 4'b0000; preset = 4'b0000;
    mode = 3'd5; a = 4'b1111; b = 4'b1111;
    tick();
    checks++; if (q !== 4'b0110) begin errors++; $display("FAIL reserved_hold got=%b exp=0110", q); end
    checks++; if (err !== 4'b0000) begin errors++; $display("FAIL reserved_err got=%b exp=0000", err); end
    a = 4'b0000; b = 4'b0000;
  endtask

  task automatic test_mid_reset();
    mode = MODE_CNT; en = 1'b1;
    tick();
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL count_to_7 got=%0d exp=7", q); end
    rst = 1'b1; preset = 4'b1000;
    tick();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL mid_reset got=%0d exp=0", q); end
    rst = 1'b0; preset = 4'b0000;
    tick();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL resume_after_reset got=%0d exp=1", q); end
  endtask

  initial begin
    test_reset();
    test_sr();
    test_jk_t();
    test_count();
    test_override();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
